// File: rtl/coefficient_serializer_if.sv
// coefficient_serializer_if
//   Block-in / bit-out bundle for the coefficient serializer.
//   master: producer side. It drives s_valid and data_in and observes the serial outputs.
//   slave : serializer side. It accepts the block and drives s_ready, bit_output,
//           is_new_bit and block_done.
//   data_in carries TABLE_SIZE coefficients in natural order.
//   Element i sits at bits [COEFF_WIDTH*i +: COEFF_WIDTH].
interface coefficient_serializer_if #(
    parameter int TABLE_SIZE  = 64,
    parameter int COEFF_WIDTH = 8
);
    logic                              s_valid;
    logic [TABLE_SIZE*COEFF_WIDTH-1:0] data_in;
    logic                              s_ready;
    logic                              bit_output;
    logic                              is_new_bit;
    logic                              block_done;

    modport master (
        output s_valid, data_in,
        input  s_ready, bit_output, is_new_bit, block_done
    );

    modport slave (
        input  s_valid, data_in,
        output s_ready, bit_output, is_new_bit, block_done
    );
endinterface

// File: rtl/coefficient_serializer.sv
// coefficient_serializer
//   Takes one 8x8 block of quantized coefficients and scans it in JPEG zig-zag order.
//   It run-length codes the block into 12-bit (run[3:0], coeff[7:0]) symbols.
//   Symbols are shifted out MSB first, one bit per cycle.
//   ZRL (run 15, coeff 0) stands for 16 zeros. EOB (0, 0) always closes the block.
// Ports
//   clk  : clock
//   rst  : synchronous, active-high reset; aborts any block in flight
//   bus  : slave side of coefficient_serializer_if
//          s_valid/s_ready handshake; block accepted only while idle
//          bit_output/is_new_bit carry the serial stream (registered)
//          block_done pulses with the last bit of EOB (registered)
module coefficient_serializer #(
    parameter int TABLE_SIZE  = 64,
    parameter int COEFF_WIDTH = 8,
    parameter int RUN_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    coefficient_serializer_if.slave   bus
);

    localparam int SYM_W = RUN_WIDTH + COEFF_WIDTH;

    // Zig-zag position -> natural (row*8+col) index.
    localparam logic [5:0] ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    localparam logic [SYM_W-1:0] SYM_EOB = '0;
    localparam logic [SYM_W-1:0] SYM_ZRL = {{RUN_WIDTH{1'b1}}, {COEFF_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT
    } state_t;

    state_t                 state_q, state_d;
    logic [6:0]             pos_q, pos_d;
    logic [RUN_WIDTH-1:0]   run_q, run_d;
    logic [SYM_W-1:0]       shreg_q, shreg_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   final_q, final_d;
    logic                   bit_q, bit_d;
    logic                   new_q, new_d;
    logic                   done_q, done_d;

    logic [COEFF_WIDTH-1:0] blk_in  [TABLE_SIZE];
    logic [COEFF_WIDTH-1:0] block_q [TABLE_SIZE];
    logic [5:0]             last_nz_c, last_nz_q;
    logic                   any_nz_c, any_nz_q;
    logic                   accept;
    logic [COEFF_WIDTH-1:0] cur_coeff;

    assign accept         = (state_q == IDLE) && bus.s_valid;
    assign bus.s_ready    = (state_q == IDLE);
    assign bus.bit_output = bit_q;
    assign bus.is_new_bit = new_q;
    assign bus.block_done = done_q;

    // Unpack the flat input bus into per-coefficient entries.
    always_comb begin
        for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
            blk_in[i] = bus.data_in[i*COEFF_WIDTH +: COEFF_WIDTH];
        end
    end

    // Highest zig-zag position holding a nonzero value. It is computed on the
    // incoming block so that it can be registered together with the data.
    always_comb begin
        last_nz_c = '0;
        any_nz_c  = 1'b0;
        for (int unsigned k = 0; k < TABLE_SIZE; k++) begin
            if (blk_in[ZZ[k]] != '0) begin
                last_nz_c = 6'(k);
                any_nz_c  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            block_q   <= blk_in;
            last_nz_q <= last_nz_c;
            any_nz_q  <= any_nz_c;
        end
    end

    assign cur_coeff = block_q[ZZ[pos_q[5:0]]];

    always_comb begin
        logic             load;
        logic [SYM_W-1:0] sym;
        logic             sym_final;

        state_d   = state_q;
        pos_d     = pos_q;
        run_d     = run_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        final_d   = final_q;
        bit_d     = 1'b0;
        new_d     = 1'b0;
        done_d    = 1'b0;
        load      = 1'b0;
        sym       = '0;
        sym_final = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.s_valid) begin
                    state_d = SCAN;
                    pos_d   = '0;
                    run_d   = '0;
                end
            end

            SCAN: begin
                if (!any_nz_q || (pos_q > {1'b0, last_nz_q}) || (pos_q == 7'd64)) begin
                    load      = 1'b1;
                    sym       = SYM_EOB;
                    sym_final = 1'b1;
                end else if (cur_coeff != '0) begin
                    load  = 1'b1;
                    sym   = {run_q, cur_coeff};
                    run_d = '0;
                    pos_d = pos_q + 7'd1;
                end else if (run_q == '1) begin
                    load  = 1'b1;
                    sym   = SYM_ZRL;
                    run_d = '0;
                    pos_d = pos_q + 7'd1;
                end else begin
                    run_d = run_q + 1'b1;
                    pos_d = pos_q + 7'd1;
                end
            end

            SHIFT: begin
                // The first bit left at load time. cnt counts the bits still to send.
                if (cnt_q != '0) begin
                    bit_d   = shreg_q[SYM_W-1];
                    shreg_d = shreg_q << 1;
                    new_d   = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                    done_d  = final_q && (cnt_q == 4'd1);
                end else begin
                    state_d = final_q ? IDLE : SCAN;
                end
            end

            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = SHIFT;
            bit_d   = sym[SYM_W-1];
            shreg_d = sym << 1;
            new_d   = 1'b1;
            cnt_d   = 4'(SYM_W - 1);
            final_d = sym_final;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            run_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            final_q <= 1'b0;
            bit_q   <= 1'b0;
            new_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            run_q   <= run_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            final_q <= final_d;
            bit_q   <= bit_d;
            new_q   <= new_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_coefficient_serializer.sv
// tb_coefficient_serializer
//   Directed bench for coefficient_serializer. Each table entry holds a block
//   and its hand-computed symbol stream: values, first-bit cycle offsets from
//   the accept cycle, and the block_done offset. Hand-written sequences cover
//   the full 64-symbol block, reset in the middle of a symbol, and back-to-back
//   accepts while s_valid stays high.
module tb_coefficient_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    coefficient_serializer_if #(.TABLE_SIZE(64), .COEFF_WIDTH(8)) bus ();

    coefficient_serializer #(
        .TABLE_SIZE (64),
        .COEFF_WIDTH(8),
        .RUN_WIDTH  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string             name;
        logic [511:0]      blk;
        int                nsym;
        logic [4:0][11:0]  syms;
        logic [4:0][7:0]   firsts;
        int                done_off;
    } vec_t;

    vec_t vecs [8];

    bit   cap_bits [$];
    int   cap_off  [$];
    int   done_off;
    logic ready_after;

    function automatic logic [511:0] nz(input int unsigned idx, input logic [7:0] v);
        return 512'(v) << (idx * 8);
    endfunction

    function automatic vec_t mk(input string n, input logic [511:0] b, input int ns,
                                input logic [11:0] s0, input logic [11:0] s1,
                                input logic [11:0] s2, input logic [11:0] s3,
                                input logic [11:0] s4,
                                input int f0, input int f1, input int f2,
                                input int f3, input int f4, input int d);
        vec_t v;
        v.name      = n;
        v.blk       = b;
        v.nsym      = ns;
        v.syms[0]   = s0;
        v.syms[1]   = s1;
        v.syms[2]   = s2;
        v.syms[3]   = s3;
        v.syms[4]   = s4;
        v.firsts[0] = 8'(f0);
        v.firsts[1] = 8'(f1);
        v.firsts[2] = 8'(f2);
        v.firsts[3] = 8'(f3);
        v.firsts[4] = 8'(f4);
        v.done_off  = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Sample from cycle t0+1 until block_done, plus one cycle for s_ready.
    task automatic collect(input int t0, input int budget, input bit drop_valid);
        int n;
        n = 0;
        cap_bits.delete();
        cap_off.delete();
        done_off = -1;
        @(negedge clk);
        if (drop_valid) begin
            bus.s_valid = 1'b0;
            bus.data_in = '0;
        end
        while (done_off < 0 && n < budget) begin
            if (bus.is_new_bit === 1'b1) begin
                cap_bits.push_back(bus.bit_output);
                cap_off.push_back(cyc - t0);
            end
            if (bus.block_done === 1'b1) done_off = cyc - t0;
            n++;
            @(negedge clk);
        end
        ready_after = bus.s_ready;
        if (done_off < 0) begin
            total++;
            bad++;
            $display("FAIL timeout: no block_done within %0d cycles", budget);
        end
    endtask

    task automatic send_block(input logic [511:0] blk, input int budget);
        int w;
        int t0;
        w = 0;
        while (bus.s_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (bus.s_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_wait: s_ready got %b required 1", bus.s_ready);
        end
        bus.data_in = blk;
        bus.s_valid = 1'b1;
        t0 = cyc;
        collect(t0, budget, 1'b1);
    endtask

    task automatic check_sym(input string tag, input int j, input logic [11:0] exp, input int first_exp);
        logic [11:0] s;
        s = '0;
        if (cap_bits.size() < 12 * (j + 1)) begin
            total++;
            bad++;
            $display("FAIL %s sym%0d missing: got %0d bits required %0d", tag, j, cap_bits.size(), 12 * (j + 1));
            return;
        end
        for (int k = 0; k < 12; k++) s = {s[10:0], cap_bits[12 * j + k]};
        check($sformatf("%s sym%0d value", tag, j), 32'(s), 32'(exp));
        check($sformatf("%s sym%0d first cycle", tag, j), cap_off[12 * j], first_exp);
        check($sformatf("%s sym%0d contiguous", tag, j), cap_off[12 * j + 11] - cap_off[12 * j], 11);
    endtask

    task automatic check_stream(input vec_t v);
        check({v.name, " bit count"}, cap_bits.size(), 12 * v.nsym);
        for (int j = 0; j < v.nsym; j++) check_sym(v.name, j, v.syms[j], int'(v.firsts[j]));
        check({v.name, " done cycle"}, done_off, v.done_off);
        check({v.name, " ready after"}, 32'(ready_after), 32'd1);
    endtask

    initial begin
        logic [511:0] ones;
        int t0;

        vecs[0] = mk("all_zero",  '0,                           1, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,  2,  0,  0,   0,   0,  13);
        vecs[1] = mk("dc_only",   nz(0, 8'h05),                 2, 12'h005, 12'h000, 12'h000, 12'h000, 12'h000,  2, 15,  0,   0,   0,  26);
        vecs[2] = mk("zz20",      nz(40, 8'hFD),                3, 12'hF00, 12'h4FD, 12'h000, 12'h000, 12'h000, 17, 34, 47,   0,   0,  58);
        vecs[3] = mk("two_zrl",   nz(35, 8'h01) | nz(29, 8'h02), 5, 12'hF00, 12'hF00, 12'h001, 12'h702, 12'h000, 17, 45, 58,  78,  91, 102);
        vecs[4] = mk("last63",    nz(63, 8'h80),                5, 12'hF00, 12'hF00, 12'hF00, 12'hF80, 12'h000, 17, 45, 73, 101, 114, 125);
        vecs[5] = mk("mixed",     nz(0, 8'hFF) | nz(1, 8'h7F) | nz(16, 8'h81),
                                                                4, 12'h0FF, 12'h07F, 12'h181, 12'h000, 12'h000,  2, 15, 29,  42,   0,  53);
        vecs[6] = mk("run15",     nz(5, 8'h10),                 2, 12'hF10, 12'h000, 12'h000, 12'h000, 12'h000, 17, 30,  0,   0,   0,  41);
        vecs[7] = mk("after_zrl", nz(12, 8'h33),                3, 12'hF00, 12'h033, 12'h000, 12'h000, 12'h000, 17, 30, 43,   0,   0,  54);

        bus.s_valid = 1'b0;
        bus.data_in = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset s_ready",    32'(bus.s_ready),    32'd1);
        check("reset is_new_bit", 32'(bus.is_new_bit), 32'd0);
        check("reset bit_output", 32'(bus.bit_output), 32'd0);
        check("reset block_done", 32'(bus.block_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send_block(vecs[i].blk, 300);
            check_stream(vecs[i]);
        end

        // Every coefficient nonzero: 64 literal symbols, then EOB.
        ones = '0;
        for (int i = 0; i < 64; i++) ones = ones | nz(i, 8'h01);
        send_block(ones, 1000);
        check("ones bit count", cap_bits.size(), 12 * 65);
        for (int j = 0; j < 64; j++) check_sym("ones", j, 12'h001, 2 + 13 * j);
        check_sym("ones", 64, 12'h000, 834);
        check("ones done cycle", done_off, 845);
        check("ones ready after", 32'(ready_after), 32'd1);

        // Reset during the 5th bit of the first symbol, with s_valid held high.
        bus.data_in = nz(0, 8'h05);
        bus.s_valid = 1'b1;
        t0 = cyc;
        repeat (6) @(negedge clk);
        check("rst 5th bit valid", 32'(bus.is_new_bit), 32'd1);
        check("rst 5th bit value", 32'(bus.bit_output), 32'd0);
        rst = 1'b1;
        bus.data_in = vecs[5].blk;
        @(negedge clk);
        check("rst is_new_bit", 32'(bus.is_new_bit), 32'd0);
        check("rst s_ready",    32'(bus.s_ready),    32'd1);
        check("rst block_done", 32'(bus.block_done), 32'd0);
        check("rst bit_output", 32'(bus.bit_output), 32'd0);
        rst = 1'b0;
        t0 = cyc;
        collect(t0, 300, 1'b0);
        check_stream(vecs[5]);

        // s_valid still high: the next block is accepted on the first ready cycle.
        t0 = cyc;
        bus.data_in = vecs[1].blk;
        collect(t0, 300, 1'b0);
        bus.s_valid = 1'b0;
        check_stream(vecs[1]);
        @(negedge clk);
        check("final idle s_ready",    32'(bus.s_ready),    32'd1);
        check("final idle is_new_bit", 32'(bus.is_new_bit), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
